dac_clk_en_seq: RTL and testbench

//  Sequencer that generates the enable for the DAC clock output stage (the ODDR2-based
//  clk_out_p/n driver, whose reset is !en) and gates the DAC data path. It orders the

---
 rtl/dac_clk_en_seq.sv | 144 ++++++++++++++
 tb/tb_dac_clk_en_seq.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/dac_clk_en_seq.sv
// rtl/dac_clk_en_seq.sv - DAC clock-enable / data-enable power sequencer
module dac_clk_en_seq #(
  parameter int SETTLE_CYC  = 16,
  parameter int WARMUP_CYC  = 8,
  parameter int FLUSH_CYC   = 4,
  parameter int OFF_MIN_CYC = 8,
  parameter int CNT_W       = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       run,
  input  logic       pll_locked,
  input  logic       err_clr,
  output logic       clk_en,
  output logic       data_en,
  output logic       active,
  output logic [2:0] state,
  output logic       lock_err
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SETTLE   = 3'd1,
    WARMUP   = 3'd2,
    RUN      = 3'd3,
    FLUSH    = 3'd4,
    OFF_HOLD = 3'd5
  } state_t;

  // Reload values are N-1 so each timed state spans exactly N cycles.
  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] WARMUP_LD = CNT_W'(WARMUP_CYC - 1);
  localparam logic [CNT_W-1:0] FLUSH_LD  = CNT_W'(FLUSH_CYC - 1);
  localparam logic [CNT_W-1:0] OFF_LD    = CNT_W'(OFF_MIN_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             cnt_done;
  logic             err_set;
  logic             err_d;

  assign cnt_done = (cnt_q == '0);
  assign state    = state_q;

  // Next-state and counter decode; lock loss outranks run drop, which outranks expiry.
  always_comb begin
    state_d = IDLE;
    cnt_d   = cnt_done ? '0 : (cnt_q - CNT_ONE);
    err_set = 1'b0;
    case (state_q)
      IDLE: begin
        state_d = IDLE;
        if (run && pll_locked) begin
          state_d = SETTLE;
          cnt_d   = SETTLE_LD;
        end
      end
      SETTLE: begin
        state_d = SETTLE;
        if (!run || !pll_locked) begin
          // Clock never ran, so no minimum off time is owed.
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_done) begin
          state_d = WARMUP;
          cnt_d   = WARMUP_LD;
        end
      end
      WARMUP: begin
        state_d = WARMUP;
        if (!pll_locked) begin
          state_d = OFF_HOLD;
          cnt_d   = OFF_LD;
          err_set = 1'b1;
        end else if (!run) begin
          state_d = FLUSH;
          cnt_d   = FLUSH_LD;
        end else if (cnt_done) begin
          state_d = RUN;
          cnt_d   = '0;
        end
      end
      RUN: begin
        state_d = RUN;
        if (!pll_locked) begin
          state_d = OFF_HOLD;
          cnt_d   = OFF_LD;
          err_set = 1'b1;
        end else if (!run) begin
          state_d = FLUSH;
          cnt_d   = FLUSH_LD;
        end
      end
      FLUSH: begin
        state_d = FLUSH;
        if (!pll_locked) begin
          state_d = OFF_HOLD;
          cnt_d   = OFF_LD;
          err_set = 1'b1;
        end else if (cnt_done) begin
          state_d = OFF_HOLD;
          cnt_d   = OFF_LD;
        end
      end
      OFF_HOLD: begin
        state_d = OFF_HOLD;
        if (cnt_done) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Sticky lock error: a new set in the clear cycle wins.
  assign err_d = err_set | (lock_err & ~err_clr);

  // State, counter and next-state-decoded output flops.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      clk_en   <= 1'b0;
      data_en  <= 1'b0;
      active   <= 1'b0;
      lock_err <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      clk_en   <= (state_d == WARMUP) || (state_d == RUN) || (state_d == FLUSH);
      data_en  <= (state_d == RUN);
      active   <= (state_d == RUN);
      lock_err <= err_d;
    end
  end

endmodule

// File: tb/tb_dac_clk_en_seq.sv
// tb/tb_dac_clk_en_seq.sv - scoreboard bench for dac_clk_en_seq
module tb_dac_clk_en_seq;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       run;
  logic       pll_locked;
  logic       err_clr;
  logic       clk_en;
  logic       data_en;
  logic       active;
  logic [2:0] state;
  logic       lock_err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int st;
    bit ce;
    bit de;
    bit ac;
    bit le;
  } exp_t;

  exp_t exp_q[$];

  // Reference model: phase code plus cycles spent in that phase.
  int m_phase;
  int m_age;
  bit m_err;

  dac_clk_en_seq dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .run        (run),
    .pll_locked (pll_locked),
    .err_clr    (err_clr),
    .clk_en     (clk_en),
    .data_en    (data_en),
    .active     (active),
    .state      (state),
    .lock_err   (lock_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  function automatic int dur(input int p);
    case (p)
      1:       return 16;
      2:       return 8;
      4:       return 4;
      5:       return 8;
      default: return 1 << 30;
    endcase
  endfunction

  function automatic bit clock_on(input int p);
    return (p == 2) || (p == 3) || (p == 4);
  endfunction

  task automatic model_reset();
    m_phase = 0;
    m_age   = 0;
    m_err   = 1'b0;
    exp_q.delete();
  endtask

  task automatic model_step(input bit r, input bit p, input bit c);
    int  np;
    bit  expired;
    bit  set_err;
    exp_t e;
    np      = m_phase;
    expired = (m_age == dur(m_phase) - 1);
    set_err = clock_on(m_phase) && !p;
    if (clock_on(m_phase) && !p) np = 5;
    else begin
      case (m_phase)
        0: if (r && p) np = 1;
        1: if (!r || !p) np = 0; else if (expired) np = 2;
        2: if (!r) np = 4; else if (expired) np = 3;
        3: if (!r) np = 4;
        4: if (expired) np = 5;
        5: if (expired) np = 0;
        default: np = 0;
      endcase
    end
    m_age   = (np != m_phase) ? 0 : m_age + 1;
    m_phase = np;
    m_err   = set_err | (m_err & !c);
    e.st = m_phase;
    e.ce = clock_on(m_phase);
    e.de = (m_phase == 3);
    e.ac = (m_phase == 3);
    e.le = m_err;
    exp_q.push_back(e);
  endtask

  // Drive one cycle of inputs at the falling edge and queue the expected response.
  task automatic step(input bit r, input bit p, input bit c);
    @(negedge clk);
    run        = r;
    pll_locked = p;
    err_clr    = c;
    model_step(r, p, c);
  endtask

  task automatic steps(input int n, input bit r, input bit p);
    for (int i = 0; i < n; i++) step(r, p, 1'b0);
  endtask

  // Monitor: compare DUT outputs just after each rising edge against the queued expectation.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("state", int'(state), e.st);
      chk("clk_en", int'(clk_en), int'(e.ce));
      chk("data_en", int'(data_en), int'(e.de));
      chk("active", int'(active), int'(e.ac));
      chk("lock_err", int'(lock_err), int'(e.le));
      if (data_en) chk("data_en_implies_clk_en", int'(clk_en), 1);
    end
  end

  initial begin
    reset_n    = 1'b0;
    run        = 1'b0;
    pll_locked = 1'b0;
    err_clr    = 1'b0;
    model_reset();
    #2;
    chk("reset_state", int'(state), 0);
    chk("reset_clk_en", int'(clk_en), 0);
    chk("reset_data_en", int'(data_en), 0);
    chk("reset_lock_err", int'(lock_err), 0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    // Power-up with default timings, then stop.
    steps(30, 1'b1, 1'b1);
    steps(15, 1'b0, 1'b1);
    // Abort during SETTLE.
    steps(5, 1'b1, 1'b1);
    steps(4, 1'b0, 1'b1);
    // Lock loss in RUN, restart, then clear colliding with a new drop.
    steps(30, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    steps(40, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    steps(10, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    // Run toggled during shutdown.
    steps(40, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b0);
    steps(40, 1'b1, 1'b1);
    // Lock loss after a restart to leave lock_err set before the async reset.
    step(1'b1, 1'b0, 1'b0);
    steps(40, 1'b1, 1'b1);

    // Async reset between edges while running.
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    chk("async_clk_en", int'(clk_en), 0);
    chk("async_data_en", int'(data_en), 0);
    chk("async_lock_err", int'(lock_err), 0);
    chk("async_active", int'(active), 0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    steps(3, 1'b0, 1'b1);

    // Randomized run / lock / clear activity.
    begin
      bit r;
      r = 1'b1;
      for (int i = 0; i < 4000; i++) begin
        if ($urandom_range(0, 39) == 0) r = ~r;
        step(r, ($urandom_range(0, 149) != 0), ($urandom_range(0, 19) == 0));
      end
    end

    @(posedge clk);
    #2;
    chk("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
